// File: rtl/text_port_arbiter_pkg.sv
// Shared definitions for the text-ROM port arbiter: default geometry,
// FSM state encoding, grant selector and the address legality rule.
package text_port_arbiter_pkg;

  // Defaults shared with the text ROM instance
  localparam int          DEF_ADDR_WIDTH     = 12;
  localparam logic [31:0] DEF_TEXT_BASE      = 32'h0000_0800;
  localparam int          DEF_MAX_DATA_BURST = 4;

  // Arbitration FSM states
  typedef enum logic {
    ARB_DPRIO    = 1'b0,
    ARB_FORCE_IF = 1'b1
  } arb_state_t;

  // Which requester owns the ROM port this cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_D    = 2'd2
  } gnt_sel_t;

  // A byte address is usable when it lies inside [base, limit) and is word aligned
  function automatic logic addr_is_legal(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] limit);
    return (addr >= base) && ({1'b0, addr} < limit) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/text_port_arbiter_if.sv
// Bundle of the fetch port, data port, ROM port and stall statistic.
// slave = arbiter view, master = pipeline/ROM view.
interface text_port_arbiter_if #(
  parameter int ADDR_WIDTH = text_port_arbiter_pkg::DEF_ADDR_WIDTH
);

  // Fetch port
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [31:0]           if_rdata;
  logic                  if_err;

  // Data port
  logic                  d_req;
  logic [31:0]           d_addr;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;
  logic                  d_err;

  // Text ROM port
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_dout;

  // Fetch stall statistic
  logic [31:0]           if_stall_cnt;

  modport slave (
    input  if_req, if_addr, d_req, d_addr, mem_dout,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_addr, if_stall_cnt
  );

  modport master (
    output if_req, if_addr, d_req, d_addr, mem_dout,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_addr, if_stall_cnt
  );

endinterface

// File: rtl/text_addr_check.sv
// Combinational range/alignment check of one requester's byte address,
// plus extraction of the ROM word index. One instance per port.
module text_addr_check
  import text_port_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [31:0] TEXT_BASE  = DEF_TEXT_BASE
) (
  input  logic [31:0]           addr,
  output logic                  legal,
  output logic [ADDR_WIDTH-1:0] word_idx
);

  // One past the last byte the ROM can hold
  localparam logic [32:0] ADDR_LIMIT = 33'd1 << (ADDR_WIDTH + 2);

  assign legal    = addr_is_legal(addr, TEXT_BASE, ADDR_LIMIT);
  assign word_idx = addr[ADDR_WIDTH+1:2];

endmodule

// File: rtl/text_port_arbiter.sv
// text_port_arbiter: shares the combinational text-ROM read port between
// instruction fetch and data (literal) reads. Data has priority, but after
// MAX_DATA_BURST data grants with a fetch waiting the fetch is forced in.
// Responses are registered one cycle after the grant; illegal addresses are
// still arbitrated but answer with err=1, rdata=0.
// Optional build macro TEXT_ARB_STATS_EN adds a saturating fetch-stall counter;
// without it if_stall_cnt is tied to zero.
module text_port_arbiter
  import text_port_arbiter_pkg::*;
#(
  parameter int          ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter logic [31:0] TEXT_BASE      = DEF_TEXT_BASE,
  parameter int          MAX_DATA_BURST = DEF_MAX_DATA_BURST
) (
  input logic                clk,
  input logic                rst_n,
  text_port_arbiter_if.slave bus
);

  localparam int                 BURST_W     = $clog2(MAX_DATA_BURST + 1);
  localparam logic [BURST_W-1:0] BURST_LIMIT = BURST_W'(MAX_DATA_BURST);

  arb_state_t            state_reg;
  logic [BURST_W-1:0]    burst_cnt_reg;
  gnt_sel_t              gnt_sel;
  logic                  if_gnt;
  logic                  d_gnt;
  logic                  if_legal;
  logic                  d_legal;
  logic [ADDR_WIDTH-1:0] if_idx;
  logic [ADDR_WIDTH-1:0] d_idx;
  logic [ADDR_WIDTH-1:0] mem_addr_reg;

  logic                  if_rvalid_reg;
  logic [31:0]           if_rdata_reg;
  logic                  if_err_reg;
  logic                  d_rvalid_reg;
  logic [31:0]           d_rdata_reg;
  logic                  d_err_reg;

  text_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TEXT_BASE  (TEXT_BASE)
  ) u_if_check (
    .addr     (bus.if_addr),
    .legal    (if_legal),
    .word_idx (if_idx)
  );

  text_addr_check #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .TEXT_BASE  (TEXT_BASE)
  ) u_d_check (
    .addr     (bus.d_addr),
    .legal    (d_legal),
    .word_idx (d_idx)
  );

  // Grant selection; nothing is granted while reset is asserted
  always_comb begin
    gnt_sel = GNT_NONE;
    if (rst_n) begin
      case (state_reg)
        ARB_FORCE_IF: begin
          if (bus.if_req)     gnt_sel = GNT_IF;
          else if (bus.d_req) gnt_sel = GNT_D;
        end
        default: begin
          if (bus.d_req)       gnt_sel = GNT_D;
          else if (bus.if_req) gnt_sel = GNT_IF;
        end
      endcase
    end
  end

  assign if_gnt     = (gnt_sel == GNT_IF);
  assign d_gnt      = (gnt_sel == GNT_D);
  assign bus.if_gnt = if_gnt;
  assign bus.d_gnt  = d_gnt;

  // ROM address follows the winner combinationally, otherwise holds
  assign bus.mem_addr = if_gnt ? if_idx :
                        d_gnt  ? d_idx  : mem_addr_reg;

  // Arbitration FSM with the anti-starvation burst counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ARB_DPRIO;
      burst_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ARB_FORCE_IF: begin
          burst_cnt_reg <= '0;
          state_reg     <= ARB_DPRIO;
        end
        default: begin
          if (!bus.if_req || if_gnt) begin
            burst_cnt_reg <= '0;
          end else if (d_gnt) begin
            burst_cnt_reg <= burst_cnt_reg + 1'b1;
            if (burst_cnt_reg + 1'b1 == BURST_LIMIT) begin
              state_reg <= ARB_FORCE_IF;
            end
          end
        end
      endcase
    end
  end

  // Registered responses: valid for one cycle after a grant, data held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_rvalid_reg <= 1'b0;
      if_rdata_reg  <= '0;
      if_err_reg    <= 1'b0;
      d_rvalid_reg  <= 1'b0;
      d_rdata_reg   <= '0;
      d_err_reg     <= 1'b0;
      mem_addr_reg  <= '0;
    end else begin
      if_rvalid_reg <= if_gnt;
      d_rvalid_reg  <= d_gnt;
      if_err_reg    <= if_gnt && !if_legal;
      d_err_reg     <= d_gnt && !d_legal;
      if (if_gnt) begin
        if_rdata_reg <= if_legal ? bus.mem_dout : 32'h0;
      end
      if (d_gnt) begin
        d_rdata_reg <= d_legal ? bus.mem_dout : 32'h0;
      end
      if (if_gnt || d_gnt) begin
        mem_addr_reg <= bus.mem_addr;
      end
    end
  end

  assign bus.if_rvalid = if_rvalid_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.if_err    = if_err_reg;
  assign bus.d_rvalid  = d_rvalid_reg;
  assign bus.d_rdata   = d_rdata_reg;
  assign bus.d_err     = d_err_reg;

`ifdef TEXT_ARB_STATS_EN
  logic [31:0] stall_cnt_reg;

  // Count cycles where a fetch waits, saturating at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_reg <= '0;
    end else if (bus.if_req && !if_gnt && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign bus.if_stall_cnt = stall_cnt_reg;
`else
  assign bus.if_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_text_port_arbiter.sv
// Bench for text_port_arbiter: directed scenarios with literal expectations
// plus a randomized phase checked every cycle against a behavioural model.
module tb_text_port_arbiter;

  localparam int          AW    = 12;
  localparam logic [31:0] BASE  = 32'h800;
  localparam int          MAXB  = 4;
`ifdef TEXT_ARB_STATS_EN
  localparam bit          STATS = 1'b1;
`else
  localparam bit          STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  text_port_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  logic [31:0] rom [0:(1<<AW)-1];
  assign bus.mem_dout = rom[bus.mem_addr];

  text_port_arbiter #(
    .ADDR_WIDTH     (AW),
    .TEXT_BASE      (BASE),
    .MAX_DATA_BURST (MAXB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_m(input logic [31:0] a);
    return (a >= BASE) && (a < (32'd1 << (AW + 2))) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)       return BASE + 4 * $urandom_range(0, (1 << AW) - 512 - 1);
    else if (k == 7) return 4 * $urandom_range(0, 511);
    else if (k == 8) return (BASE + 4 * $urandom_range(0, 100)) + $urandom_range(1, 3);
    else             return $urandom | 32'h4000;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_if_gnt"},   bus.if_gnt,       0);
    check({tag, "_d_gnt"},    bus.d_gnt,        0);
    check({tag, "_if_rv"},    bus.if_rvalid,    0);
    check({tag, "_if_rdata"}, bus.if_rdata,     0);
    check({tag, "_if_err"},   bus.if_err,       0);
    check({tag, "_d_rv"},     bus.d_rvalid,     0);
    check({tag, "_d_rdata"},  bus.d_rdata,      0);
    check({tag, "_d_err"},    bus.d_err,        0);
    check({tag, "_mem_addr"}, bus.mem_addr,     0);
    check({tag, "_stall"},    bus.if_stall_cnt, 0);
  endtask

  // Behavioural model state
  int          streak;
  bit          m_gi, m_gd;
  logic [31:0] m_ga;
  logic [AW-1:0] m_maddr, exp_ma;
  bit          m_if_v, m_if_e, m_d_v, m_d_e;
  logic [31:0] m_if_d, m_d_d, m_stall;

  // Per-cycle compare against the model, then advance the model across the edge
  always @(negedge clk) begin
    if (!rst_n) begin
      streak = 0;
      m_if_v = 0; m_if_e = 0; m_if_d = 0;
      m_d_v  = 0; m_d_e  = 0; m_d_d  = 0;
      m_maddr = '0;
      m_stall = 0;
    end else if (chk_en) begin
      m_gi = 0;
      m_gd = 0;
      if (bus.if_req && streak >= MAXB) m_gi = 1;
      else if (bus.d_req)               m_gd = 1;
      else if (bus.if_req)              m_gi = 1;
      m_ga   = m_gi ? bus.if_addr : (m_gd ? bus.d_addr : 32'h0);
      exp_ma = (m_gi || m_gd) ? AW'(m_ga >> 2) : m_maddr;

      check("cyc_if_gnt",    bus.if_gnt,       m_gi);
      check("cyc_d_gnt",     bus.d_gnt,        m_gd);
      check("cyc_mem_addr",  bus.mem_addr,     exp_ma);
      check("cyc_if_rvalid", bus.if_rvalid,    m_if_v);
      check("cyc_if_rdata",  bus.if_rdata,     m_if_d);
      check("cyc_if_err",    bus.if_err,       m_if_e);
      check("cyc_d_rvalid",  bus.d_rvalid,     m_d_v);
      check("cyc_d_rdata",   bus.d_rdata,      m_d_d);
      check("cyc_d_err",     bus.d_err,        m_d_e);
      check("cyc_stall",     bus.if_stall_cnt, m_stall);

      if (STATS && bus.if_req && !m_gi && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (!bus.if_req || m_gi) streak = 0;
      else if (m_gd)           streak = streak + 1;

      m_if_v = m_gi;
      m_if_e = m_gi && !legal_m(m_ga);
      if (m_gi) m_if_d = legal_m(m_ga) ? rom[int'(m_ga >> 2)] : 32'h0;
      m_d_v = m_gd;
      m_d_e = m_gd && !legal_m(m_ga);
      if (m_gd) m_d_d = legal_m(m_ga) ? rom[int'(m_ga >> 2)] : 32'h0;
      if (m_gi || m_gd) m_maddr = exp_ma;
    end
  end

  // Stimulus
  initial begin
    bit ig, dg;
    bit [1:0] pat;
    for (int i = 0; i < (1 << AW); i++) rom[i] = $urandom;
    rom[512] = 32'h0015_0513;

    // Reset with both requests high: everything must stay zero
    bus.if_req = 1; bus.d_req = 1;
    bus.if_addr = 32'h800; bus.d_addr = 32'h804;
    #12;
    check_all_zero("rst");
    bus.if_req = 0; bus.d_req = 0;
    @(negedge clk); #1 rst_n = 1;
    step();
    chk_en = 1;

    // Test 1: single fetch
    bus.if_req = 1; bus.if_addr = 32'h800;
    #1;
    check("t1_if_gnt", bus.if_gnt, 1);
    check("t1_d_gnt", bus.d_gnt, 0);
    check("t1_mem_addr", bus.mem_addr, 512);
    step();
    bus.if_req = 0;
    check("t1_if_rvalid", bus.if_rvalid, 1);
    check("t1_if_rdata", bus.if_rdata, 32'h0015_0513);
    check("t1_if_err", bus.if_err, 0);
    step();
    check("t1_rvalid_drop", bus.if_rvalid, 0);
    check("t1_rdata_hold", bus.if_rdata, 32'h0015_0513);

    // Test 2: both requesting for 10 cycles -> D,D,D,D,IF,D,D,D,D,IF
    for (int i = 0; i < 10; i++) begin
      bus.if_req = 1; bus.if_addr = 32'h800 + 4 * i;
      bus.d_req  = 1; bus.d_addr  = 32'h900 + 4 * i;
      #1;
      pat = (i == 4 || i == 9) ? 2'b10 : 2'b01;
      check($sformatf("t2_pattern_%0d", i), {bus.if_gnt, bus.d_gnt}, pat);
      if (i == 4) check("t2_stall_cnt", bus.if_stall_cnt, STATS ? 32'd4 : 32'd0);
      step();
    end
    bus.if_req = 0; bus.d_req = 0;
    step();

    // Tests 3/4: illegal data addresses, then an unaffected fetch
    bus.d_req = 1; bus.d_addr = 32'h7FC;
    step();
    bus.d_addr = 32'h802;
    check("t3_below_rv", bus.d_rvalid, 1);
    check("t3_below_err", bus.d_err, 1);
    check("t3_below_rdata", bus.d_rdata, 0);
    step();
    bus.d_addr = 32'h4000;
    check("t3_misal_rv", bus.d_rvalid, 1);
    check("t3_misal_err", bus.d_err, 1);
    check("t3_misal_rdata", bus.d_rdata, 0);
    step();
    bus.d_req = 0;
    bus.if_req = 1; bus.if_addr = 32'h804;
    check("t4_range_rv", bus.d_rvalid, 1);
    check("t4_range_err", bus.d_err, 1);
    check("t4_range_rdata", bus.d_rdata, 0);
    step();
    bus.if_req = 0;
    check("t4_if_rv", bus.if_rvalid, 1);
    check("t4_if_err", bus.if_err, 0);
    check("t4_if_rdata", bus.if_rdata, rom[513]);
    step();

    // Randomized traffic; each request is held until granted
    ig = 0; dg = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!bus.if_req || ig) begin
        bus.if_req  = ($urandom_range(0, 9) < 6);
        bus.if_addr = rand_addr();
      end
      if (!bus.d_req || dg) begin
        bus.d_req  = ($urandom_range(0, 9) < 6);
        bus.d_addr = rand_addr();
      end
      @(negedge clk);
      ig = bus.if_gnt;
      dg = bus.d_gnt;
      step();
    end
    bus.if_req = 0; bus.d_req = 0;
    step();
    step();

    // Test 5: reset asserted during the response cycle
    bus.if_req = 1; bus.if_addr = 32'h800;
    step();
    bus.if_req = 0;
    check("t5_rv_before", bus.if_rvalid, 1);
    chk_en = 0;
    #1 rst_n = 0;
    #1;
    check_all_zero("t5");
    @(negedge clk); #1 rst_n = 1;
    step();
    chk_en = 1;
    bus.if_req = 1; bus.if_addr = 32'h800;
    #1;
    check("t5_if_gnt", bus.if_gnt, 1);
    check("t5_mem_addr", bus.mem_addr, 512);
    step();
    bus.if_req = 0;
    check("t5_if_rvalid", bus.if_rvalid, 1);
    check("t5_if_rdata", bus.if_rdata, 32'h0015_0513);
    check("t5_if_err", bus.if_err, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
